// File: rtl/ast_arb_pkg.sv
// Shared types and default sizes for the Avalon-ST packet arbiter and its picker.
package ast_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int N_SRC_DEF     = 4;
  localparam int DATA_W_DEF    = 64;
  localparam int CHANNEL_W_DEF = 10;

endpackage

// File: rtl/ast_rr_pick.sv
// Combinational rotate-priority picker: first asserted request at or after ptr_i, wrapping.
module ast_rr_pick
  import ast_arb_pkg::*;
#(
  parameter  int N_SRC = N_SRC_DEF,
  localparam int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [SRC_W-1:0] ptr_i,
  output logic             any_req_o,
  output logic [SRC_W-1:0] winner_o
);

  always_comb begin
    any_req_o = |req_i;
    winner_o  = '0;
    // Scan from the farthest offset down so the closest requester to ptr_i wins last.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N_SRC]) begin
        winner_o = SRC_W'((int'(ptr_i) + i) % N_SRC);
      end
    end
  end

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-locked round-robin arbiter feeding one Avalon-ST sink from N_SRC sources.
// Optional AST_ARB_SRC_TAG_EN: replace the low channel bits with the granted source index.
module ast_packet_arbiter
  import ast_arb_pkg::*;
#(
  parameter  int N_SRC     = N_SRC_DEF,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int EMPTY_W   = $clog2(DATA_W / 8),
  parameter  int CHANNEL_W = CHANNEL_W_DEF,
  localparam int SRC_W     = $clog2(N_SRC)
) (
  input  logic                       clk_i,
  input  logic                       srst_i,
  input  logic [N_SRC*DATA_W-1:0]    ast_data_i,
  input  logic [N_SRC*EMPTY_W-1:0]   ast_empty_i,
  input  logic [N_SRC*CHANNEL_W-1:0] ast_channel_i,
  input  logic [N_SRC-1:0]           ast_startofpacket_i,
  input  logic [N_SRC-1:0]           ast_endofpacket_i,
  input  logic [N_SRC-1:0]           ast_valid_i,
  output logic [N_SRC-1:0]           ast_ready_o,
  output logic [DATA_W-1:0]          ast_data_o,
  output logic [EMPTY_W-1:0]         ast_empty_o,
  output logic [CHANNEL_W-1:0]       ast_channel_o,
  output logic                       ast_startofpacket_o,
  output logic                       ast_endofpacket_o,
  output logic                       ast_valid_o,
  input  logic                       ast_ready_i,
  output logic [SRC_W-1:0]           arb_grant_o,
  output logic                       arb_busy_o
);

`ifdef AST_ARB_SRC_TAG_EN
  if (CHANNEL_W < SRC_W) begin : g_chan_w_check
    $error("ast_packet_arbiter: CHANNEL_W must be >= SRC_W when source tagging is enabled");
  end
`endif

  arb_state_t       state_q, state_d;
  logic [SRC_W-1:0] grant_q, grant_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_SRC-1:0] req;
  logic             any_req;
  logic [SRC_W-1:0] winner;
  logic             busy;
  logic             beat_xfer;

  logic [DATA_W-1:0]    data_arr [N_SRC];
  logic [EMPTY_W-1:0]   empty_arr[N_SRC];
  logic [CHANNEL_W-1:0] chan_arr [N_SRC];

  for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
    assign data_arr[k]  = ast_data_i[k*DATA_W +: DATA_W];
    assign empty_arr[k] = ast_empty_i[k*EMPTY_W +: EMPTY_W];
    assign chan_arr[k]  = ast_channel_i[k*CHANNEL_W +: CHANNEL_W];
  end

  assign req       = ast_valid_i & ast_startofpacket_i;
  assign busy      = (state_q == ARB_BUSY);
  assign beat_xfer = ast_valid_o & ast_ready_i;

  ast_rr_pick #(
    .N_SRC(N_SRC)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .any_req_o(any_req),
    .winner_o (winner)
  );

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d = winner;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (beat_xfer && ast_endofpacket_o) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_q == SRC_W'(N_SRC - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    ast_data_o          = data_arr[grant_q];
    ast_empty_o         = empty_arr[grant_q];
    ast_channel_o       = chan_arr[grant_q];
`ifdef AST_ARB_SRC_TAG_EN
    ast_channel_o[SRC_W-1:0] = grant_q;
`endif
    ast_startofpacket_o = ast_startofpacket_i[grant_q];
    ast_endofpacket_o   = ast_endofpacket_i[grant_q];
    ast_valid_o         = busy & ast_valid_i[grant_q];
    ast_ready_o         = '0;
    // Idle: beats arriving without sop belong to no packet and are flushed.
    if (busy) begin
      ast_ready_o[grant_q] = ast_ready_i;
    end else begin
      ast_ready_o = ast_valid_i & ~ast_startofpacket_i;
    end
  end

  assign arb_busy_o  = busy;
  assign arb_grant_o = grant_q;

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Directed bench for ast_packet_arbiter with N_SRC=4, DATA_W=64, CHANNEL_W=10.
module tb_ast_packet_arbiter;

  logic         clk_i = 1'b0;
  logic         srst_i;
  logic [255:0] ast_data_i;
  logic [11:0]  ast_empty_i;
  logic [39:0]  ast_channel_i;
  logic [3:0]   ast_startofpacket_i;
  logic [3:0]   ast_endofpacket_i;
  logic [3:0]   ast_valid_i;
  logic [3:0]   ast_ready_o;
  logic [63:0]  ast_data_o;
  logic [2:0]   ast_empty_o;
  logic [9:0]   ast_channel_o;
  logic         ast_startofpacket_o;
  logic         ast_endofpacket_o;
  logic         ast_valid_o;
  logic         ast_ready_i;
  logic [1:0]   arb_grant_o;
  logic         arb_busy_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ast_packet_arbiter #(
    .N_SRC(4), .DATA_W(64), .CHANNEL_W(10)
  ) dut (
    .clk_i              (clk_i),
    .srst_i             (srst_i),
    .ast_data_i         (ast_data_i),
    .ast_empty_i        (ast_empty_i),
    .ast_channel_i      (ast_channel_i),
    .ast_startofpacket_i(ast_startofpacket_i),
    .ast_endofpacket_i  (ast_endofpacket_i),
    .ast_valid_i        (ast_valid_i),
    .ast_ready_o        (ast_ready_o),
    .ast_data_o         (ast_data_o),
    .ast_empty_o        (ast_empty_o),
    .ast_channel_o      (ast_channel_o),
    .ast_startofpacket_o(ast_startofpacket_o),
    .ast_endofpacket_o  (ast_endofpacket_o),
    .ast_valid_o        (ast_valid_o),
    .ast_ready_i        (ast_ready_i),
    .arb_grant_o        (arb_grant_o),
    .arb_busy_o         (arb_busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic set_src(input int k, input logic v, input logic s, input logic e,
                         input logic [63:0] d, input logic [9:0] ch);
    ast_valid_i[k]         = v;
    ast_startofpacket_i[k] = s;
    ast_endofpacket_i[k]   = e;
    ast_data_i[k*64 +: 64] = d;
    ast_channel_i[k*10 +: 10] = ch;
    ast_empty_i[k*3 +: 3]  = 3'(k + 1);
  endtask

  task automatic clr_all();
    for (int k = 0; k < 4; k++) set_src(k, 1'b0, 1'b0, 1'b0, 64'h0, 10'h0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(ast_valid_o), 64'd0);
    chk({tag, "_busy"},  64'(arb_busy_o), 64'd0);
  endtask

  logic [5:0]  rdy_pat;
  logic [63:0] bp_beat [4];
  logic [9:0]  exp_ch;
  int          b;

  initial begin
    srst_i      = 1'b0;
    ast_ready_i = 1'b0;
    clr_all();
    tick();
    tick();
    chk("rst_valid", 64'(ast_valid_o), 64'd0);
    chk("rst_ready", 64'(ast_ready_o), 64'd0);
    chk("rst_busy",  64'(arb_busy_o),  64'd0);
    chk("rst_grant", 64'(arb_grant_o), 64'd0);

    // Single source, 3-beat packet from src2
    srst_i      = 1'b1;
    ast_ready_i = 1'b1;
    set_src(2, 1'b1, 1'b1, 1'b0, 64'hB200_0001, 10'h012);
    #1;
    chk("s2_bubble_valid", 64'(ast_valid_o), 64'd0);
    chk("s2_bubble_ready", 64'(ast_ready_o), 64'd0);
    tick();
    chk("s2_b1_grant", 64'(arb_grant_o), 64'd2);
    chk("s2_b1_busy",  64'(arb_busy_o),  64'd1);
    chk("s2_b1_valid", 64'(ast_valid_o), 64'd1);
    chk("s2_b1_data",  ast_data_o,       64'hB200_0001);
    chk("s2_b1_sop",   64'(ast_startofpacket_o), 64'd1);
    chk("s2_b1_empty", 64'(ast_empty_o), 64'd3);
    chk("s2_b1_ready", 64'(ast_ready_o), 64'h4);
    tick();
    set_src(2, 1'b1, 1'b0, 1'b0, 64'hB200_0002, 10'h012);
    #1;
    chk("s2_b2_data", ast_data_o, 64'hB200_0002);
    chk("s2_b2_sop",  64'(ast_startofpacket_o), 64'd0);
    chk("s2_b2_eop",  64'(ast_endofpacket_o),   64'd0);
    tick();
    set_src(2, 1'b1, 1'b0, 1'b1, 64'hB200_0003, 10'h012);
    #1;
    chk("s2_b3_data", ast_data_o, 64'hB200_0003);
    chk("s2_b3_eop",  64'(ast_endofpacket_o), 64'd1);
    tick();
    set_src(2, 1'b0, 1'b0, 1'b0, 64'h0, 10'h0);
    #1;
    chk_idle("s2_done");
    chk("s2_grant_hold", 64'(arb_grant_o), 64'd2);

    // rr_ptr is now 3: src3 beats src0, then src0 follows
    set_src(0, 1'b1, 1'b1, 1'b1, 64'hA0, 10'h000);
    set_src(3, 1'b1, 1'b1, 1'b1, 64'hA3, 10'h000);
    #1;
    chk("rr_idle_ready", 64'(ast_ready_o), 64'd0);
    tick();
    chk("rr_grant3", 64'(arb_grant_o), 64'd3);
    chk("rr_data3",  ast_data_o,       64'hA3);
    chk("rr_ready3", 64'(ast_ready_o), 64'h8);
    tick();
    set_src(3, 1'b0, 1'b0, 1'b0, 64'h0, 10'h0);
    #1;
    chk_idle("rr_gap");
    tick();
    chk("rr_grant0", 64'(arb_grant_o), 64'd0);
    chk("rr_data0",  ast_data_o,       64'hA0);
    tick();
    clr_all();

    // All four sources continuously offering single-beat packets from reset
    srst_i = 1'b0;
    for (int k = 0; k < 4; k++) set_src(k, 1'b1, 1'b1, 1'b1, 64'hC0 + 64'(k), 10'h0);
    tick();
    srst_i = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("all_bubble", 64'(ast_valid_o), 64'd0);
      tick();
      chk("all_grant", 64'(arb_grant_o), 64'(i % 4));
      chk("all_valid", 64'(ast_valid_o), 64'd1);
      chk("all_data",  ast_data_o,       64'hC0 + 64'(i % 4));
      tick();
    end

    // Backpressure on a 4-beat src1 packet while src0 waits with sop
    clr_all();
    srst_i = 1'b0;
    tick();
    srst_i = 1'b1;
    bp_beat[0] = 64'hD100; bp_beat[1] = 64'hD101;
    bp_beat[2] = 64'hD102; bp_beat[3] = 64'hD103;
    set_src(1, 1'b1, 1'b1, 1'b0, bp_beat[0], 10'h0);
    tick();
    set_src(0, 1'b1, 1'b1, 1'b1, 64'hD0, 10'h0);
    rdy_pat = 6'b111001;
    b = 0;
    for (int c = 0; c < 6; c++) begin
      ast_ready_i = rdy_pat[c];
      set_src(1, 1'b1, (b == 0), (b == 3), bp_beat[b], 10'h0);
      #1;
      chk("bp_grant", 64'(arb_grant_o), 64'd1);
      chk("bp_valid", 64'(ast_valid_o), 64'd1);
      chk("bp_data",  ast_data_o,       bp_beat[b]);
      chk("bp_ready", 64'(ast_ready_o), {61'd0, rdy_pat[c], 2'b00} >> 1);
      tick();
      if (rdy_pat[c]) b++;
    end
    chk("bp_beats", 64'(b), 64'd4);
    set_src(1, 1'b0, 1'b0, 1'b0, 64'h0, 10'h0);
    #1;
    chk_idle("bp_gap");
    chk("bp_wait_ready", 64'(ast_ready_o), 64'd0);
    tick();
    chk("bp_next_grant", 64'(arb_grant_o), 64'd0);
    chk("bp_next_data",  ast_data_o,       64'hD0);
    chk("bp_next_ready", 64'(ast_ready_o), 64'h1);
    tick();
    clr_all();

    // Orphan beats on src3 while idle
    set_src(3, 1'b1, 1'b0, 1'b0, 64'hE3, 10'h0);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("orph_ready", 64'(ast_ready_o), 64'h8);
      chk_idle("orph");
      tick();
    end
    clr_all();

    // Reset in the middle of a 5-beat src2 packet
    set_src(2, 1'b1, 1'b1, 1'b0, 64'hF200, 10'h0);
    tick();
    chk("mr_grant2", 64'(arb_grant_o), 64'd2);
    tick();
    set_src(2, 1'b1, 1'b0, 1'b0, 64'hF201, 10'h0);
    #1;
    chk("mr_b2_data", ast_data_o, 64'hF201);
    srst_i = 1'b0;
    tick();
    srst_i = 1'b1;
    set_src(2, 1'b1, 1'b0, 1'b0, 64'hF202, 10'h0);
    #1;
    chk_idle("mr_after");
    chk("mr_grant", 64'(arb_grant_o), 64'd0);
    chk("mr_flush", 64'(ast_ready_o), 64'h4);
    set_src(0, 1'b1, 1'b1, 1'b1, 64'hF0, 10'h0);
    set_src(2, 1'b1, 1'b1, 1'b0, 64'hF200, 10'h0);
    tick();
    chk("mr_restart_grant", 64'(arb_grant_o), 64'd0);
    set_src(2, 1'b0, 1'b0, 1'b0, 64'h0, 10'h0);
    tick();
    clr_all();

    // Channel field from src3 (tagged when AST_ARB_SRC_TAG_EN is defined)
`ifdef AST_ARB_SRC_TAG_EN
    exp_ch = 10'h3F3;
`else
    exp_ch = 10'h3F0;
`endif
    set_src(3, 1'b1, 1'b1, 1'b1, 64'h33, 10'h3F0);
    set_src(2, 1'b0, 1'b0, 1'b0, 64'h0,  10'h2A5);
    tick();
    chk("ch_grant", 64'(arb_grant_o),   64'd3);
    chk("ch_value", 64'(ast_channel_o), 64'(exp_ch));
    tick();
    clr_all();
    #1;
    chk_idle("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
